// File: rtl/credit_sender.sv
// rtl/credit_sender.sv - credit-gated transmit queue feeding a credit counter
module credit_sender #(
    parameter int data_sz  = 32,
    parameter int count_sz = 10,
    parameter int depth    = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enq__ENA,
    input  logic [data_sz-1:0]        enq_data,
    input  logic [count_sz-1:0]       enq_len,
    output logic                      enq__RDY,
    output logic                      out__ENA,
    output logic [data_sz-1:0]        out_data,
    output logic [count_sz-1:0]       out_len,
    input  logic                      out__RDY,
    output logic                      maybeDecrement__ENA,
    output logic [count_sz-1:0]       maybeDecrement_v,
    input  logic                      maybeDecrement,
    output logic [$clog2(depth):0]    pending,
    output logic [15:0]               stall_count,
    output logic                      overflow
);
    localparam int ptr_sz = $clog2(depth);
    localparam logic [ptr_sz:0]   c_full    = (ptr_sz + 1)'(depth);
    localparam logic [ptr_sz:0]   c_one     = (ptr_sz + 1)'(1);
    localparam logic [ptr_sz-1:0] c_ptr_one = ptr_sz'(1);

    logic [data_sz-1:0]  r_data_mem [depth];
    logic [count_sz-1:0] r_len_mem  [depth];
    logic [ptr_sz-1:0]   r_rd_ptr;
    logic [ptr_sz-1:0]   r_wr_ptr;
    logic [ptr_sz:0]     r_pending;
    logic [15:0]         r_stall;
    logic                r_overflow;

    logic w_head_valid;
    logic w_req;
    logic w_fire;
    logic w_enq_ok;
    logic w_not_full;

    assign w_head_valid = (r_pending != '0);
    assign w_not_full   = (r_pending != c_full);
    assign w_req        = w_head_valid & out__RDY;
    assign w_fire       = w_req & maybeDecrement;
    assign w_enq_ok     = enq__ENA & w_not_full;

    assign enq__RDY            = w_not_full;
    assign out__ENA            = w_fire;
    assign out_data            = r_data_mem[r_rd_ptr];
    assign out_len             = r_len_mem[r_rd_ptr];
    assign maybeDecrement__ENA = w_req;
    // The counter debits v whenever it grants, so v must be zero without a request.
    assign maybeDecrement_v    = w_req ? r_len_mem[r_rd_ptr] : '0;
    assign pending             = r_pending;
    assign stall_count         = r_stall;
    assign overflow            = r_overflow;

    always_ff @(posedge CLK) begin
        if (w_enq_ok) begin
            r_data_mem[r_wr_ptr] <= enq_data;
            r_len_mem[r_wr_ptr]  <= enq_len;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_pending  <= '0;
            r_stall    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            case ({w_enq_ok, w_fire})
                2'b10:   r_pending <= r_pending + c_one;
                2'b01:   r_pending <= r_pending - c_one;
                default: r_pending <= r_pending;
            endcase
            if (enq__ENA && !w_not_full) begin
                r_overflow <= 1'b1;
            end
            // Only a request refused for lack of credit counts; downstream backpressure does not.
            if (w_req && !maybeDecrement && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_credit_sender.sv
// tb/tb_credit_sender.sv - bench for credit_sender paired with a credit counter model
module tb_credit_sender;
    localparam int DW = 32;
    localparam int CW = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          enq__ENA = 1'b0;
    logic [DW-1:0] enq_data = '0;
    logic [CW-1:0] enq_len = '0;
    logic          enq__RDY;
    logic          out__ENA;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_len;
    logic          out__RDY = 1'b0;
    logic          maybeDecrement__ENA;
    logic [CW-1:0] maybeDecrement_v;
    logic          maybeDecrement;
    logic [2:0]    pending;
    logic [15:0]   stall_count;
    logic          overflow;

    logic [CW-1:0] cnt;
    logic [CW-1:0] inc = '0;
    logic [CW-1:0] ld_val = '0;
    logic          ld = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    credit_sender #(.data_sz(DW), .count_sz(CW), .depth(4)) dut (
        .CLK(CLK), .RST(RST),
        .enq__ENA(enq__ENA), .enq_data(enq_data), .enq_len(enq_len), .enq__RDY(enq__RDY),
        .out__ENA(out__ENA), .out_data(out_data), .out_len(out_len), .out__RDY(out__RDY),
        .maybeDecrement__ENA(maybeDecrement__ENA), .maybeDecrement_v(maybeDecrement_v),
        .maybeDecrement(maybeDecrement),
        .pending(pending), .stall_count(stall_count), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Credit counter: grants when it holds at least v, and debits v on every grant.
    assign maybeDecrement = (cnt >= maybeDecrement_v);
    always @(posedge CLK) begin
        if (ld) cnt <= ld_val;
        else    cnt <= cnt - (maybeDecrement ? maybeDecrement_v : '0) + inc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [31:0] d, input logic [9:0] l,
                         input logic r, input logic [9:0] i);
        @(negedge CLK);
        enq__ENA = e; enq_data = d; enq_len = l; out__RDY = r; inc = i;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        enq__ENA = 0; out__RDY = 0; inc = 0; RST = 1;
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic load_cnt(input logic [9:0] v);
        @(negedge CLK);
        enq__ENA = 0; out__RDY = 0; inc = 0; ld = 1; ld_val = v;
        @(negedge CLK);
        ld = 0;
    endtask

    typedef struct {
        logic        e;
        logic [31:0] d;
        logic [9:0]  l;
        logic        r;
        logic [9:0]  i;
        logic        x_rdy;
        logic        x_ena;
        logic [31:0] x_data;
        logic [2:0]  x_pend;
        logic [15:0] x_stall;
        logic [9:0]  x_cnt;
    } vec_t;

    vec_t tbl[9];

    logic [31:0] qd[$];
    int          ql[$];
    int          mcnt, mstall, psize;
    bit          movf, has, req, grant;
    logic        re, rr;
    logic [31:0] rd;
    logic [9:0]  rl, ri;

    initial begin
        // starvation then zero-cost, starting from reset with an empty counter
        tbl[0] = '{1'b1, 32'hA5, 10'd5, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd0, 16'd0, 10'd0};
        tbl[1] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd1, 16'd0, 10'd0};
        tbl[2] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd1, 16'd1, 10'd0};
        tbl[3] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd5, 1'b1, 1'b0, 32'h0, 3'd1, 16'd2, 10'd0};
        tbl[4] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b1, 32'hA5, 3'd1, 16'd3, 10'd5};
        tbl[5] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd0, 16'd3, 10'd0};
        tbl[6] = '{1'b1, 32'h11, 10'd0, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd0, 16'd3, 10'd0};
        tbl[7] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b1, 32'h11, 3'd1, 16'd3, 10'd0};
        tbl[8] = '{1'b0, 32'h0,  10'd0, 1'b1, 10'd0, 1'b1, 1'b0, 32'h0, 3'd0, 16'd3, 10'd0};

        RST = 1;
        #3;
        chk("reset_enq_rdy", enq__RDY, 1);
        chk("reset_out_ena", out__ENA, 0);
        chk("reset_md_ena", maybeDecrement__ENA, 0);
        chk("reset_md_v", maybeDecrement_v, 0);
        chk("reset_pending", pending, 0);
        chk("reset_stall", stall_count, 0);
        chk("reset_overflow", overflow, 0);
        @(negedge CLK);
        RST = 0;
        load_cnt(0);

        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].e, tbl[k].d, tbl[k].l, tbl[k].r, tbl[k].i);
            chk($sformatf("tbl%0d_enq_rdy", k), enq__RDY, tbl[k].x_rdy);
            chk($sformatf("tbl%0d_out_ena", k), out__ENA, tbl[k].x_ena);
            if (tbl[k].x_ena) chk($sformatf("tbl%0d_data", k), out_data, tbl[k].x_data);
            chk($sformatf("tbl%0d_pending", k), pending, tbl[k].x_pend);
            chk($sformatf("tbl%0d_stall", k), stall_count, tbl[k].x_stall);
            chk($sformatf("tbl%0d_cnt", k), cnt, tbl[k].x_cnt);
            chk($sformatf("tbl%0d_overflow", k), overflow, 0);
        end

        // back-to-back: 10 credits cover three len-3 entries, the fourth stalls
        do_reset();
        load_cnt(10);
        for (int k = 0; k < 4; k++) drive(1, 32'h100 + k, 3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("b2b_ena%0d", k), out__ENA, (k < 3) ? 1 : 0);
            if (k < 3) chk($sformatf("b2b_data%0d", k), out_data, 32'h100 + k);
        end
        drive(0, 0, 0, 1, 0);
        chk("b2b_cnt", cnt, 1);
        chk("b2b_pending", pending, 1);
        chk("b2b_stall", stall_count, 2);

        // backpressure: no request while downstream is not ready
        do_reset();
        load_cnt(20);
        drive(1, 32'h77, 4, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0);
            chk($sformatf("bp_v%0d", k), maybeDecrement_v, 0);
            chk($sformatf("bp_mdena%0d", k), maybeDecrement__ENA, 0);
            chk($sformatf("bp_ena%0d", k), out__ENA, 0);
        end
        chk("bp_cnt_hold", cnt, 20);
        chk("bp_stall", stall_count, 0);
        drive(0, 0, 0, 1, 0);
        chk("bp_fire", out__ENA, 1);
        chk("bp_data", out_data, 32'h77);
        chk("bp_v", maybeDecrement_v, 4);
        drive(0, 0, 0, 0, 0);
        chk("bp_cnt_after", cnt, 16);
        chk("bp_pending", pending, 0);

        // full/overflow with pointers offset by one so the fill wraps
        do_reset();
        load_cnt(0);
        drive(1, 32'h1FF, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("ovf_pre_data", out_data, 32'h1FF);
        for (int k = 0; k < 4; k++) drive(1, 32'h200 + k, 0, 0, 0);
        drive(1, 32'h2FF, 0, 0, 0);
        chk("ovf_enq_rdy", enq__RDY, 0);
        chk("ovf_pending_full", pending, 4);
        chk("ovf_not_yet", overflow, 0);
        drive(0, 0, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_pending_hold", pending, 4);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("ovf_drain_ena%0d", k), out__ENA, 1);
            chk($sformatf("ovf_drain_data%0d", k), out_data, 32'h200 + k);
        end
        drive(0, 0, 0, 0, 0);
        chk("ovf_empty", pending, 0);
        chk("ovf_sticky", overflow, 1);

        // async reset mid-transfer, overflow still set from above
        load_cnt(100);
        for (int k = 0; k < 3; k++) drive(1, 32'h300 + k, 1, 0, 0);
        @(negedge CLK);
        enq__ENA = 0; out__RDY = 1; inc = 0;
        #1;
        chk("ar_ena_before", out__ENA, 1);
        #1 RST = 1;
        #1;
        chk("ar_ena", out__ENA, 0);
        chk("ar_pending", pending, 0);
        chk("ar_overflow", overflow, 0);
        chk("ar_enq_rdy", enq__RDY, 1);
        chk("ar_md_v", maybeDecrement_v, 0);
        #1 RST = 0;
        drive(1, 32'h3C, 2, 1, 0);
        chk("ar_post_pending", pending, 0);
        drive(0, 0, 0, 1, 0);
        chk("ar_post_ena", out__ENA, 1);
        chk("ar_post_data", out_data, 32'h3C);
        drive(0, 0, 0, 0, 0);
        chk("ar_post_cnt", cnt, 98);
        chk("ar_post_empty", pending, 0);

        // randomized traffic against a queue-based reference
        do_reset();
        load_cnt(0);
        mcnt = 0; mstall = 0; movf = 0;
        qd.delete(); ql.delete();
        for (int c = 0; c < 400; c++) begin
            re = ($urandom_range(0, 2) != 0);
            rd = $urandom;
            rl = 10'($urandom_range(0, 6));
            rr = ($urandom_range(0, 3) != 0);
            ri = (mcnt > 900) ? 10'd0 : 10'($urandom_range(0, 3));
            drive(re, rd, rl, rr, ri);
            psize = qd.size();
            has   = (psize > 0);
            req   = has && rr;
            grant = req && (mcnt >= ql[0]);
            chk("rnd_enq_rdy", enq__RDY, (psize != 4) ? 1 : 0);
            chk("rnd_pending", pending, psize);
            chk("rnd_ena", out__ENA, grant ? 1 : 0);
            chk("rnd_md_ena", maybeDecrement__ENA, req ? 1 : 0);
            chk("rnd_md_v", maybeDecrement_v, req ? ql[0] : 0);
            if (has) begin
                chk("rnd_data", out_data, qd[0]);
                chk("rnd_len", out_len, ql[0]);
            end
            chk("rnd_stall", stall_count, mstall);
            chk("rnd_overflow", overflow, movf ? 1 : 0);
            chk("rnd_cnt", cnt, mcnt);
            if (grant) begin
                mcnt -= ql[0];
                void'(qd.pop_front());
                void'(ql.pop_front());
            end else if (req && mstall < 65535) begin
                mstall++;
            end
            if (re) begin
                if (psize < 4) begin
                    qd.push_back(rd);
                    ql.push_back(int'(rl));
                end else begin
                    movf = 1;
                end
            end
            mcnt += int'(ri);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
